multicycle_control_fsm: RTL and testbench

- Sequencing controller of the RV32I multi-cycle core; sits upstream of the datapath muxes and register/memory write enables.
- Walks each instruction through FETCH, DECODE and execute/writeback states, keyed on the 7-bit opcode.
- Issues per-cycle datapath selects and write strobes.
- Stalls on a memory-ready handshake and traps permanently on unsupported opcodes.

---
 rtl/multicycle_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the RV32I multi-cycle core: walks each instruction
// through fetch/decode/execute states and drives datapath selects and strobes.
module multicycle_control_fsm #(
    parameter int unsigned          STATE_W     = 4,
    parameter logic [STATE_W-1:0]   RESET_STATE = STATE_W'(0)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECR    = STATE_W'(6),
        S_ALUWB    = STATE_W'(7),
        S_EXECI    = STATE_W'(8),
        S_JAL      = STATE_W'(9),
        S_BEQ      = STATE_W'(10),
        S_TRAP     = STATE_W'(11)
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q;
    logic   pc_update;
    logic   branch;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky trap flag, armed on the decode-to-trap transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_DECODE && state_d == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // PC and IR load only on the completing cycle, so stalls never double-increment
                IRWrite   = mem_ready;
                pc_update = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        PCWrite = pc_update | (branch & zero);

        // Reset masks all strobes and parks the muxes on fetch values
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            AdrSrc     = 1'b0;
            ResultSrc  = 2'b10;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b10;
            ALUOp      = 2'b00;
        end
    end

    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle vectors queued
// by the stimulus process, popped and compared by a negedge monitor.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic       done;
        logic       ill;
    } exp_t;

    typedef struct {
        exp_t  e;
        string nm;
    } sb_item_t;

    //                        st     pcw   adr   mw    irw   rw    rs     sa     sb     aop    done  ill
    localparam exp_t E_RST  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam exp_t F_RDY  = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam exp_t F_STL  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam exp_t E_DEC  = '{4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam exp_t E_MADR = '{4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam exp_t E_MRD  = '{4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam exp_t E_MWB  = '{4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam exp_t W_STL  = '{4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam exp_t W_RDY  = '{4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam exp_t E_EXR  = '{4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam exp_t E_AWB  = '{4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam exp_t E_EXI  = '{4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
    localparam exp_t E_JAL  = '{4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam exp_t B_TKN  = '{4'd10,1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam exp_t B_NTK  = '{4'd10,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam exp_t E_TRAP = '{4'd11,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic       instr_done, illegal;
    logic [3:0] dbg_state;

    sb_item_t   sb[$];
    int         checks = 0;
    int         errors = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .illegal    (illegal),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Monitor: compare the oldest queued expectation against this cycle's outputs
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_item_t it;
            exp_t     act;
            it  = sb.pop_front();
            act = '{dbg_state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal};
            checks++;
            if (act !== it.e) begin
                errors++;
                $display("FAIL %s: got st=%0d vec=%h, expected st=%0d vec=%h",
                         it.nm, act.st, act, it.e.st, it.e);
            end
        end
    end

    task automatic push(input exp_t e, input string nm);
        sb_item_t it;
        it.e  = e;
        it.nm = nm;
        sb.push_back(it);
    endtask

    // One cycle: drive inputs just after the edge, queue the expected outputs
    task automatic cyc(input logic mr, input logic z, input logic [6:0] o,
                       input exp_t e, input string nm);
        mem_ready = mr;
        zero      = z;
        op        = o;
        push(e, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        op        = OP_REG;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, OP_REG, E_RST, "reset_hold");
        reset = 1'b0;

        // R-type, no stalls: 0,1,6,7
        cyc(1'b1, 1'b0, OP_REG, F_RDY, "r_fetch");
        cyc(1'b1, 1'b0, OP_REG, E_DEC, "r_decode");
        cyc(1'b1, 1'b0, OP_REG, E_EXR, "r_execr");
        cyc(1'b1, 1'b0, OP_REG, E_AWB, "r_aluwb");

        // Load with 3 stall cycles in MEMREAD
        cyc(1'b1, 1'b0, OP_LOAD, F_RDY, "ld_fetch");
        cyc(1'b1, 1'b0, OP_LOAD, E_DEC, "ld_decode");
        cyc(1'b1, 1'b0, OP_LOAD, E_MADR, "ld_memadr");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, OP_LOAD, E_MRD, "ld_memread_stall");
        cyc(1'b1, 1'b0, OP_LOAD, E_MRD, "ld_memread_rdy");
        cyc(1'b1, 1'b0, OP_LOAD, E_MWB, "ld_memwb");

        // Store with 2 stall cycles in MEMWRITE
        cyc(1'b1, 1'b0, OP_STORE, F_RDY, "st_fetch");
        cyc(1'b1, 1'b0, OP_STORE, E_DEC, "st_decode");
        cyc(1'b1, 1'b0, OP_STORE, E_MADR, "st_memadr");
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, OP_STORE, W_STL, "st_memwrite_stall");
        cyc(1'b1, 1'b0, OP_STORE, W_RDY, "st_memwrite_rdy");

        // Branch taken, then not taken
        cyc(1'b1, 1'b1, OP_BRANCH, F_RDY, "beq1_fetch");
        cyc(1'b1, 1'b1, OP_BRANCH, E_DEC, "beq1_decode");
        cyc(1'b1, 1'b1, OP_BRANCH, B_TKN, "beq_taken");
        cyc(1'b1, 1'b0, OP_BRANCH, F_RDY, "beq0_fetch");
        cyc(1'b1, 1'b0, OP_BRANCH, E_DEC, "beq0_decode");
        cyc(1'b1, 1'b0, OP_BRANCH, B_NTK, "beq_not_taken");

        // Fetch stalled 5 cycles, then I-type
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, OP_IMM, F_STL, "fetch_stall");
        cyc(1'b1, 1'b0, OP_IMM, F_RDY, "i_fetch");
        cyc(1'b1, 1'b0, OP_IMM, E_DEC, "i_decode");
        cyc(1'b1, 1'b0, OP_IMM, E_EXI, "i_execi");
        cyc(1'b1, 1'b0, OP_IMM, E_AWB, "i_aluwb");

        // JAL
        cyc(1'b1, 1'b0, OP_JAL, F_RDY, "jal_fetch");
        cyc(1'b1, 1'b0, OP_JAL, E_DEC, "jal_decode");
        cyc(1'b1, 1'b0, OP_JAL, E_JAL, "jal_exec");
        cyc(1'b1, 1'b0, OP_JAL, E_AWB, "jal_aluwb");

        // Unsupported opcode traps until reset regardless of inputs
        cyc(1'b1, 1'b0, OP_BAD, F_RDY, "bad_fetch");
        cyc(1'b1, 1'b0, OP_BAD, E_DEC, "bad_decode");
        for (int i = 0; i < 12; i++)
            cyc(1'(i % 2), 1'(i % 3 == 0), (i % 2 == 0) ? OP_REG : OP_BAD, E_TRAP, "trap_hold");

        // Asynchronous reset mid-cycle: takes effect before the next edge
        mem_ready = 1'b1;
        #2;
        reset = 1'b1;
        push(E_RST, "async_reset_midcycle");
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, OP_REG, E_RST, "reset_held");
        reset = 1'b0;

        // Recovery after trap
        cyc(1'b1, 1'b0, OP_REG, F_RDY, "post_fetch");
        cyc(1'b1, 1'b0, OP_REG, E_DEC, "post_decode");
        cyc(1'b1, 1'b0, OP_REG, E_EXR, "post_execr");
        cyc(1'b1, 1'b0, OP_REG, E_AWB, "post_aluwb");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
